rename_alloc_stage: RTL and testbench
=====================================

Name: rename_alloc_stage

Overview:
- Parametrised N-wide physical-register allocation stage.
- Sits between decode and the reservation stations.
- Owns a circular free list and assigns a physical register to every lane of a decode group that writes a destination. Allocation is all-or-nothing per group.
- Checkpoints the free-list head per branch tag, so a branch shootdown reclaims all registers allocated after that branch.
- Commit returns retired registers through a multi-lane free port.

Parameters:
- WIDTH, 4: lanes per decode group.
- FREE_WIDTH, 2: commit free lanes per cycle.
- NUM_PREGS, 64: physical registers.
- NUM_AREGS, 32: architectural registers. Pregs 0..NUM_AREGS-1 are mapped at reset.
- MAX_PREDICT_DEPTH_BITS, 2: branch tag width. The checkpoint table has 2^MAX_PREDICT_DEPTH_BITS entries.
- Derived: DEPTH = NUM_PREGS-NUM_AREGS; PB = $clog2(NUM_PREGS); CB = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode group present.
- in_ready  out  1  group accepted this cycle when in_valid && in_ready.
- in_needs_dest  in  WIDTH  lane i writes a destination.
- in_is_branch  in  WIDTH  lane i is a branch and takes a checkpoint.
- in_branch_tag  in  WIDTH*MAX_PREDICT_DEPTH_BITS  checkpoint tag per lane.
- out_valid  out  1  allocated group held in the output register.
- out_ready  in  1  downstream consumes the group.
- out_alloc  out  WIDTH  lane i received a preg.
- out_preg  out  WIDTH*PB  preg per lane; 0 where out_alloc[i]=0.
- out_num_alloc  out  $clog2(WIDTH+1)  popcount of out_alloc.
- free_valid  in  FREE_WIDTH  commit returns a register on this lane.
- free_preg  in  FREE_WIDTH*PB  returned preg.
- branch_shootdown  in  1  mispredict recovery.
- shootdown_branch_tag  in  MAX_PREDICT_DEPTH_BITS  tag to restore.
- num_free  out  CB  current free count.

Behaviour:
- Storage: DEPTH-entry ring buffer with head and tail pointers, each carrying an extra wrap bit. num_free = tail-head (CB bits).
- Reset (asynchronous, active-high):
  - ring[k] = NUM_AREGS+k; head=0; tail=DEPTH; num_free=DEPTH.
  - out_valid=0, out_alloc=0, out_preg=0, out_num_alloc=0.
  - Checkpoint table cleared to 0.
- need = popcount(in_needs_dest).
- in_ready = !branch_shootdown && (num_free >= need) && (!out_valid || out_ready). Combinational.
- Accept (in_valid && in_ready):
  - Lane i gets ring[head + popcount(in_needs_dest[i-1:0])]. Lower lanes always get older entries.
  - head += need.
  - Output register loads out_alloc=in_needs_dest, out_preg, out_num_alloc=need, out_valid=1.
  - Latency: 1 cycle from acceptance to out_valid.
- Checkpoint: each accepted lane with in_is_branch writes ckpt[tag] = head + popcount(in_needs_dest[i:0]), i.e. the head after this lane's own allocation.
  - The branch's destination survives shootdown; younger lanes' destinations do not.
  - Multiple branches in one group with the same tag: the highest lane wins.
- Hold: out_valid && !out_ready keeps all outputs stable. No group is accepted while held.
- Drain: out_valid && out_ready && !accept sets out_valid=0 next cycle.
- Free: each free_valid lane writes ring[tail + offset] in lane order; tail += popcount(free_valid).
  - Freed entries count toward num_free and in_ready from the next cycle only.
  - Same-cycle allocate and free are both applied.
  - A free that would make num_free exceed DEPTH is a protocol error and is covered by an assertion.
- Shootdown, with priority over accept:
  - head = ckpt[shootdown_branch_tag].
  - out_valid=0 next cycle.
  - No accept that cycle.
  - Frees in the same cycle are still applied.
  - Tags the caller never checkpointed are undefined.
- Wrap-around: head and tail wrap modulo DEPTH for indexing; the wrap bit distinguishes full from empty.
- need=0 groups are accepted whenever the output register is free, including when num_free=0.

Test Plan:
- Reset, then group needs_dest=1111 -> out_preg={35,34,33,32} (lane3..lane0) one cycle later; num_free=28.
- needs_dest=1010 -> lane1=first free preg, lane3=next; lane0 and lane2 out_preg=0; out_num_alloc=2.
- Allocate down to num_free=2, then present a group needing 3 -> in_ready=0. Free 1 preg -> in_ready=1 the cycle after the free; the allocated lanes include the freed preg once the ring wraps.
- out_ready=0 with out_valid=1 -> outputs stable for 5 cycles and in_ready=0. Raise out_ready -> next group issues the following cycle.
- Group 1111 with lane1 a branch (tag 2), then another 1111, then branch_shootdown tag 2 -> num_free rises by 6; the next allocation returns the preg that followed lane1's preg; out_valid=0 the cycle after shootdown.
- Allocate and free continuously for 3*DEPTH pregs -> no lost or duplicated pregs; num_free correct across head/tail wrap.
- Reset asserted mid-hold -> out_valid=0 and num_free=32 immediately.

Source files
------------

// File: rtl/rename_alloc_stage_if.sv
// rtl/rename_alloc_stage_if.sv - decode, output, commit-free and shootdown bundle for the rename allocator
interface rename_alloc_stage_if #(
   parameter int WIDTH                  = 4,
   parameter int FREE_WIDTH             = 2,
   parameter int NUM_PREGS              = 64,
   parameter int NUM_AREGS              = 32,
   parameter int MAX_PREDICT_DEPTH_BITS = 2
);
   localparam int PB = $clog2(NUM_PREGS);
   localparam int CB = $clog2(NUM_PREGS - NUM_AREGS + 1);
   localparam int NA = $clog2(WIDTH + 1);

   logic                                    in_valid;
   logic                                    in_ready;
   logic [WIDTH-1:0]                        in_needs_dest;
   logic [WIDTH-1:0]                        in_is_branch;
   logic [WIDTH*MAX_PREDICT_DEPTH_BITS-1:0] in_branch_tag;
   logic                                    out_valid;
   logic                                    out_ready;
   logic [WIDTH-1:0]                        out_alloc;
   logic [WIDTH*PB-1:0]                     out_preg;
   logic [NA-1:0]                           out_num_alloc;
   logic [FREE_WIDTH-1:0]                   free_valid;
   logic [FREE_WIDTH*PB-1:0]                free_preg;
   logic                                    branch_shootdown;
   logic [MAX_PREDICT_DEPTH_BITS-1:0]       shootdown_branch_tag;
   logic [CB-1:0]                           num_free;

   modport master (
      output in_valid, in_needs_dest, in_is_branch, in_branch_tag, out_ready,
             free_valid, free_preg, branch_shootdown, shootdown_branch_tag,
      input  in_ready, out_valid, out_alloc, out_preg, out_num_alloc, num_free
   );

   modport slave (
      input  in_valid, in_needs_dest, in_is_branch, in_branch_tag, out_ready,
             free_valid, free_preg, branch_shootdown, shootdown_branch_tag,
      output in_ready, out_valid, out_alloc, out_preg, out_num_alloc, num_free
   );
endinterface

// File: rtl/rename_alloc_stage.sv
// rtl/rename_alloc_stage.sv - N-wide physical register allocator with circular free list and branch checkpoints
module rename_alloc_stage #(
   parameter int WIDTH                  = 4,
   parameter int FREE_WIDTH             = 2,
   parameter int NUM_PREGS              = 64,
   parameter int NUM_AREGS              = 32,
   parameter int MAX_PREDICT_DEPTH_BITS = 2
) (
   input logic              clk,
   input logic              reset,
   rename_alloc_stage_if.slave bus
);
   localparam int DEPTH = NUM_PREGS - NUM_AREGS;
   localparam int PB    = $clog2(NUM_PREGS);
   localparam int CB    = $clog2(DEPTH + 1);
   localparam int NA    = $clog2(WIDTH + 1);
   localparam int MB    = MAX_PREDICT_DEPTH_BITS;
   localparam int NCK   = 1 << MB;
   localparam int IW    = $clog2(DEPTH);
   // Pointers count modulo 2*DEPTH: the upper half acts as the wrap bit, even for non-power-of-two DEPTH.
   localparam int PW    = $clog2(2 * DEPTH);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [IW-1:0] idx_t;

   function automatic ptr_t ptr_add(input ptr_t p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= 2 * DEPTH) s -= 2 * DEPTH;
      return ptr_t'(s);
   endfunction

   function automatic idx_t idx_of(input ptr_t p);
      if (p >= ptr_t'(DEPTH)) return idx_t'(p - ptr_t'(DEPTH));
      return idx_t'(p);
   endfunction

   logic [PB-1:0]       ring_q [DEPTH];
   logic [PB-1:0]       ring_d [DEPTH];
   ptr_t                ckpt_q [NCK];
   ptr_t                ckpt_d [NCK];
   ptr_t                head_q, head_d, tail_q, tail_d;
   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_alloc_q, out_alloc_d;
   logic [WIDTH*PB-1:0] out_preg_q, out_preg_d;
   logic [NA-1:0]       out_num_alloc_q, out_num_alloc_d;
   logic [WIDTH*PB-1:0] preg_vec;
   int                  need, nfree, free_cnt;
   logic                in_ready_c, accept;

   always_comb begin
      int            pre;
      int            off;
      logic [PB-1:0] lane_preg;
      need        = 0;
      nfree       = 0;
      pre         = 0;
      off         = 0;
      lane_preg   = '0;
      preg_vec    = '0;
      ring_d      = ring_q;
      ckpt_d      = ckpt_q;
      head_d      = head_q;
      tail_d      = tail_q;
      out_valid_d     = out_valid_q;
      out_alloc_d     = out_alloc_q;
      out_preg_d      = out_preg_q;
      out_num_alloc_d = out_num_alloc_q;

      for (int i = 0; i < WIDTH; i++) need += int'(bus.in_needs_dest[i]);
      for (int j = 0; j < FREE_WIDTH; j++) nfree += int'(bus.free_valid[j]);

      free_cnt = int'(tail_q) - int'(head_q);
      if (free_cnt < 0) free_cnt += 2 * DEPTH;
      in_ready_c = !bus.branch_shootdown && (free_cnt >= need) && (!out_valid_q || bus.out_ready);
      accept     = bus.in_valid && in_ready_c;

      // Lanes take consecutive ring entries in lane order; a branch checkpoints the head just past its own preg.
      for (int i = 0; i < WIDTH; i++) begin
         lane_preg = ring_q[idx_of(ptr_add(head_q, pre))];
         if (bus.in_needs_dest[i]) begin
            preg_vec[i*PB +: PB] = lane_preg;
            pre++;
         end
         if (accept && bus.in_is_branch[i])
            ckpt_d[bus.in_branch_tag[i*MB +: MB]] = ptr_add(head_q, pre);
      end

      for (int j = 0; j < FREE_WIDTH; j++) begin
         if (bus.free_valid[j]) begin
            ring_d[idx_of(ptr_add(tail_q, off))] = bus.free_preg[j*PB +: PB];
            off++;
         end
      end
      tail_d = ptr_add(tail_q, off);

      if (bus.branch_shootdown) begin
         head_d      = ckpt_q[bus.shootdown_branch_tag];
         out_valid_d = 1'b0;
      end else if (accept) begin
         head_d          = ptr_add(head_q, need);
         out_valid_d     = 1'b1;
         out_alloc_d     = bus.in_needs_dest;
         out_preg_d      = preg_vec;
         out_num_alloc_d = NA'(need);
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) ring_q[k] <= PB'(NUM_AREGS + k);
         for (int k = 0; k < NCK; k++) ckpt_q[k] <= '0;
         head_q          <= '0;
         tail_q          <= ptr_t'(DEPTH);
         out_valid_q     <= 1'b0;
         out_alloc_q     <= '0;
         out_preg_q      <= '0;
         out_num_alloc_q <= '0;
      end else begin
         ring_q          <= ring_d;
         ckpt_q          <= ckpt_d;
         head_q          <= head_d;
         tail_q          <= tail_d;
         out_valid_q     <= out_valid_d;
         out_alloc_q     <= out_alloc_d;
         out_preg_q      <= out_preg_d;
         out_num_alloc_q <= out_num_alloc_d;
      end
   end

   assign bus.in_ready      = in_ready_c;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_alloc     = out_alloc_q;
   assign bus.out_preg      = out_preg_q;
   assign bus.out_num_alloc = out_num_alloc_q;
   assign bus.num_free      = CB'(free_cnt);

   // Commit may never return more registers than are currently outstanding.
   ap_no_overfree: assert property (@(posedge clk) disable iff (reset) (free_cnt + nfree) <= DEPTH);
endmodule

// File: tb/tb_rename_alloc_stage.sv
// tb/tb_rename_alloc_stage.sv - directed and streaming checks of rename_alloc_stage against a queue model
module tb_rename_alloc_stage;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rename_alloc_stage_if #(.WIDTH(4), .FREE_WIDTH(2), .NUM_PREGS(64), .NUM_AREGS(32),
                           .MAX_PREDICT_DEPTH_BITS(2)) bus ();

   rename_alloc_stage #(.WIDTH(4), .FREE_WIDTH(2), .NUM_PREGS(64), .NUM_AREGS(32),
                        .MAX_PREDICT_DEPTH_BITS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Model: free list as a FIFO of preg numbers, allocation history as a list; a checkpoint is a history length.
   int       fq[$];
   int       hist[$];
   int       mck[4];
   bit       owned[64];
   logic     m_ov;
   logic [3:0] m_alloc;
   int       m_preg[4];
   int       m_num;
   bit       in_stress = 0;
   int       stress_alloc = 0;

   function automatic int pc4(input logic [3:0] x);
      return int'(x[0]) + int'(x[1]) + int'(x[2]) + int'(x[3]);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int lane(input int i);
      return int'(bus.out_preg[6*i +: 6]);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         fq.delete();
         hist.delete();
         for (int k = 0; k < 32; k++) fq.push_back(32 + k);
         for (int k = 0; k < 4; k++) begin mck[k] = 0; m_preg[k] = 0; end
         for (int k = 0; k < 64; k++) owned[k] = 0;
         m_ov = 0; m_alloc = 0; m_num = 0;
      end else begin
         int need, c, p;
         logic rdy, acc;
         need = pc4(bus.in_needs_dest);
         rdy  = !bus.branch_shootdown && (fq.size() >= need) && (!m_ov || bus.out_ready);
         acc  = bus.in_valid && rdy;
         if (bus.branch_shootdown) begin
            c = mck[bus.shootdown_branch_tag];
            while (hist.size() > c) begin
               p = hist.pop_back();
               fq.push_front(p);
               owned[p] = 0;
            end
            m_ov = 0;
         end else if (acc) begin
            for (int i = 0; i < 4; i++) begin
               m_preg[i] = 0;
               if (bus.in_needs_dest[i]) begin
                  p = fq.pop_front();
                  hist.push_back(p);
                  owned[p] = 1;
                  m_preg[i] = p;
               end
               if (bus.in_is_branch[i]) mck[bus.in_branch_tag[2*i +: 2]] = hist.size();
            end
            m_ov = 1; m_alloc = bus.in_needs_dest; m_num = need;
            if (in_stress) stress_alloc += need;
         end else if (bus.out_ready) begin
            m_ov = 0;
         end
         for (int j = 0; j < 2; j++) begin
            if (bus.free_valid[j]) begin
               p = int'(bus.free_preg[6*j +: 6]);
               fq.push_back(p);
               owned[p] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         int exp_rdy;
         exp_rdy = (!bus.branch_shootdown && (fq.size() >= pc4(bus.in_needs_dest)) &&
                    (!m_ov || bus.out_ready)) ? 1 : 0;
         chk("in_ready", int'(bus.in_ready), exp_rdy);
         chk("num_free", int'(bus.num_free), fq.size());
         chk("out_valid", int'(bus.out_valid), int'(m_ov));
         if (m_ov) begin
            chk("out_alloc", int'(bus.out_alloc), int'(m_alloc));
            chk("out_num_alloc", int'(bus.out_num_alloc), m_num);
            for (int i = 0; i < 4; i++) chk("out_preg_lane", lane(i), m_preg[i]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] nd, input logic [3:0] br,
                        input logic [7:0] tg, input logic ordy);
      bus.in_valid = v; bus.in_needs_dest = nd; bus.in_is_branch = br;
      bus.in_branch_tag = tg; bus.out_ready = ordy;
   endtask

   task automatic set_free(input logic [1:0] fv, input int p0, input int p1);
      bus.free_valid = fv;
      bus.free_preg  = {6'(p1), 6'(p0)};
   endtask

   task automatic pick_free(input int want);
      int sel[2];
      int n, start, p;
      n = 0; sel[0] = 0; sel[1] = 0;
      start = int'($urandom_range(0, 63));
      for (int k = 0; k < 64; k++) begin
         p = (start + k) % 64;
         if (n < want && owned[p]) begin sel[n] = p; n++; end
      end
      set_free((n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00, sel[0], sel[1]);
   endtask

   function automatic int owned_count();
      int n = 0;
      for (int k = 0; k < 64; k++) n += int'(owned[k]);
      return n;
   endfunction

   initial begin
      int hold_lane[4];
      int guard;
      drive(0, 4'b0, 4'b0, 8'b0, 1);
      set_free(2'b00, 0, 0);
      bus.branch_shootdown = 0; bus.shootdown_branch_tag = 0;
      #1 reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;

      chk("rst_num_free", int'(bus.num_free), 32);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_preg", int'(bus.out_preg), 0);
      chk("rst_in_ready", int'(bus.in_ready), 1);

      drive(1, 4'b1111, 4'b0, 8'b0, 1); step(); bus.in_valid = 0;
      chk("g1_lane0", lane(0), 32); chk("g1_lane1", lane(1), 33);
      chk("g1_lane2", lane(2), 34); chk("g1_lane3", lane(3), 35);
      chk("g1_num_free", int'(bus.num_free), 28);

      drive(1, 4'b1010, 4'b0, 8'b0, 1); step(); bus.in_valid = 0;
      chk("g2_lane0", lane(0), 0);  chk("g2_lane1", lane(1), 36);
      chk("g2_lane2", lane(2), 0);  chk("g2_lane3", lane(3), 37);
      chk("g2_num_alloc", int'(bus.out_num_alloc), 2);

      repeat (6) begin drive(1, 4'b1111, 4'b0, 8'b0, 1); step(); end
      drive(1, 4'b0111, 4'b0, 8'b0, 1); #1;
      chk("low_num_free", int'(bus.num_free), 2);
      chk("low_in_ready", int'(bus.in_ready), 0);
      step();
      set_free(2'b01, 32, 0); #1;
      chk("free_cycle_in_ready", int'(bus.in_ready), 0);
      step(); set_free(2'b00, 0, 0); #1;
      chk("after_free_in_ready", int'(bus.in_ready), 1);
      step(); bus.in_valid = 0;
      chk("wrap_lane0", lane(0), 62); chk("wrap_lane1", lane(1), 63);
      chk("wrap_lane2", lane(2), 32); chk("wrap_num_free", int'(bus.num_free), 0);

      set_free(2'b11, 33, 34); step();
      set_free(2'b11, 35, 36); step();
      set_free(2'b00, 0, 0);
      chk("hold_pre_num_free", int'(bus.num_free), 4);
      drive(1, 4'b1111, 4'b0, 8'b0, 0); step();
      drive(1, 4'b0000, 4'b0, 8'b0, 0);
      hold_lane = '{33, 34, 35, 36};
      repeat (5) begin
         step();
         chk("hold_out_valid", int'(bus.out_valid), 1);
         chk("hold_in_ready", int'(bus.in_ready), 0);
         for (int i = 0; i < 4; i++) chk("hold_lane", lane(i), hold_lane[i]);
      end
      bus.out_ready = 1; #1;
      chk("zero_need_ready", int'(bus.in_ready), 1);
      step(); bus.in_valid = 0;
      chk("zero_need_valid", int'(bus.out_valid), 1);
      chk("zero_need_num", int'(bus.out_num_alloc), 0);
      step();

      set_free(2'b11, 37, 38); step();
      set_free(2'b11, 39, 40); step();
      set_free(2'b11, 41, 42); step();
      set_free(2'b11, 43, 44); step();
      set_free(2'b00, 0, 0);
      chk("br_pre_num_free", int'(bus.num_free), 8);
      drive(1, 4'b1111, 4'b0010, 8'b0000_1000, 1); step();
      drive(1, 4'b1111, 4'b0000, 8'b0, 1); step(); bus.in_valid = 0;
      chk("br_alloc_num_free", int'(bus.num_free), 0);
      bus.branch_shootdown = 1; bus.shootdown_branch_tag = 2; step();
      bus.branch_shootdown = 0;
      chk("sd_num_free", int'(bus.num_free), 6);
      chk("sd_out_valid", int'(bus.out_valid), 0);
      drive(1, 4'b0001, 4'b0, 8'b0, 1); step(); bus.in_valid = 0;
      chk("sd_next_preg", lane(0), 39);

      in_stress = 1;
      guard = 0;
      while (stress_alloc < 96 && guard < 3000) begin
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'b0, 8'b0, 1);
         pick_free(int'($urandom_range(0, 2)));
         step();
         guard++;
      end
      in_stress = 0;
      drive(0, 4'b0, 4'b0, 8'b0, 1);
      set_free(2'b00, 0, 0);
      chk("stress_volume", (stress_alloc >= 96) ? 1 : 0, 1);
      step();
      chk("stress_conservation", int'(bus.num_free), 32 - owned_count());

      guard = 0;
      while (owned_count() > 0 && guard < 100) begin pick_free(2); step(); guard++; end
      set_free(2'b00, 0, 0); step();
      chk("drain_num_free", int'(bus.num_free), 32);

      drive(1, 4'b0011, 4'b0, 8'b0, 0); step(); bus.in_valid = 0;
      step(); step();
      chk("mid_hold_valid", int'(bus.out_valid), 1);
      #2 reset = 1;
      #1;
      chk("async_rst_out_valid", int'(bus.out_valid), 0);
      chk("async_rst_num_free", int'(bus.num_free), 32);
      @(posedge clk); #1 reset = 0;
      bus.out_ready = 1;
      step();
      chk("post_rst_num_free", int'(bus.num_free), 32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
